// File: rtl/ram_lat_model_pkg.sv
// ram_model_pkg: shared types, limits and byte-lane merge helper for the latency RAM model.
package ram_model_pkg;

    typedef enum logic {REF_IDLE, REF_BUSY} ref_state_t;

    localparam int MAX_RD_LAT     = 4;
    localparam int MAX_REF_CYCLES = 15;

    function automatic logic [7:0] lane_merge(input logic [7:0] old_v, input logic [7:0] new_v,
                                              input logic we);
        return we ? new_v : old_v;
    endfunction

endpackage

// File: rtl/ram_lat_model_if.sv
// ram_lat_model_if: RAM_* request/response bus between a requester and the latency RAM model.
interface ram_lat_model_if #(
    parameter int AW = 18,
    parameter int DW = 16
);
    logic [AW-1:0]   ram_a;
    logic [DW-1:0]   ram_d;
    logic [DW/8-1:0] ram_we;
    logic            ram_rd;
    logic            ram_cs;
    logic [DW-1:0]   ram_q;
    logic            ram_rdy;
    logic            ram_busy;

    modport master (
        output ram_a, ram_d, ram_we, ram_rd, ram_cs,
        input  ram_q, ram_rdy, ram_busy
    );

    modport slave (
        input  ram_a, ram_d, ram_we, ram_rd, ram_cs,
        output ram_q, ram_rdy, ram_busy
    );

endinterface

// File: rtl/ram_refresh_timer.sv
// ram_refresh_timer: periodic refresh stall generator; busy for REF_CYCLES after every REF_PERIOD idle cycles.
module ram_refresh_timer
    import ram_model_pkg::*;
#(
    parameter int REF_PERIOD = 0,
    parameter int REF_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic busy
);
    localparam int CW = REF_PERIOD > 1 ? $clog2(REF_PERIOD) : 1;

    ref_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    stall_q, stall_d;

    // The period counter holds its wrap value during the stall and restarts from zero afterwards.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        case (state_q)
            REF_IDLE:
                if (REF_PERIOD != 0) begin
                    if (cnt_q == CW'(REF_PERIOD - 1)) begin
                        state_d = REF_BUSY;
                        stall_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            REF_BUSY:
                if (stall_q == 4'(REF_CYCLES - 1)) begin
                    state_d = REF_IDLE;
                    cnt_d   = '0;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REF_IDLE;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign busy = state_q == REF_BUSY;

endmodule

// File: rtl/ram_lat_model.sv
// ram_lat_model: parametrised bench RAM with byte-lane writes, pipelined read latency and refresh stalls.
module ram_lat_model
    import ram_model_pkg::*;
#(
    parameter int    AW         = 18,
    parameter int    DW         = 16,
    parameter string INIT_FILE  = "",
    parameter int    RD_LAT     = 1,
    parameter int    REF_PERIOD = 0,
    parameter int    REF_CYCLES = 4
) (
    input logic            clk,
    input logic            rst_n,
    ram_lat_model_if.slave bus
);
    localparam int NB = DW / 8;

    if (DW % 8 != 0 || DW < 8) begin : g_bad_dw
        $error("ram_lat_model: DW must be a non-zero multiple of 8");
    end
    if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
        $error("ram_lat_model: RD_LAT must be within 1..4");
    end
    if (REF_CYCLES < 1 || REF_CYCLES > MAX_REF_CYCLES) begin : g_bad_ref
        $error("ram_lat_model: REF_CYCLES must be within 1..15");
    end

    logic [DW-1:0]     mem [2**AW];
    logic              busy, accept, wr_en, rd_en;
    logic [DW-1:0]     wr_word, rd_word;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [AW-1:0]     adr_q [RD_LAT];
    logic [AW-1:0]     adr_d [RD_LAT];
    logic              rdy_q, rdy_d;
    logic [DW-1:0]     q_q, q_d;

    initial for (int k = 0; k < 2**AW; k++) mem[k] = '0;

    ram_refresh_timer #(
        .REF_PERIOD(REF_PERIOD),
        .REF_CYCLES(REF_CYCLES)
    ) u_refresh (
        .clk  (clk),
        .rst_n(rst_n),
        .busy (busy)
    );

    assign accept = bus.ram_cs & ~busy & (bus.ram_rd | (|bus.ram_we));
    assign wr_en  = accept & (|bus.ram_we);
    assign rd_en  = accept & bus.ram_rd;

    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign wr_word[8*i +: 8] = lane_merge(mem[bus.ram_a][8*i +: 8], bus.ram_d[8*i +: 8], bus.ram_we[i]);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[bus.ram_a] <= wr_word;
    end

    assign rd_word = mem[adr_q[RD_LAT-1]];

    always_comb begin
        vld_d    = '0;
        adr_d    = adr_q;
        vld_d[0] = rd_en;
        adr_d[0] = bus.ram_a;
        for (int k = 1; k < RD_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            adr_d[k] = adr_q[k-1];
        end
        rdy_d = vld_q[RD_LAT-1];
        q_d   = vld_q[RD_LAT-1] ? rd_word : q_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            rdy_q <= 1'b0;
            q_q   <= '0;
        end else begin
            vld_q <= vld_d;
            rdy_q <= rdy_d;
            q_q   <= q_d;
        end
    end

    always_ff @(posedge clk) begin
        adr_q <= adr_d;
    end

    assign bus.ram_q    = q_q;
    assign bus.ram_rdy  = rdy_q;
    assign bus.ram_busy = busy;

endmodule

// File: tb/tb_ram_lat_model.sv
// tb_ram_lat_model: two RAM configurations driven in lockstep and checked against a queue/array model.
module tb_ram_lat_model;
    localparam int AW   = 10;
    localparam int DW   = 16;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
    localparam int PER1 = 100;
    localparam int CYC  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    we;
    logic          rd, cs;
    logic [1:0]    rdy_w, busy_w;
    logic [DW-1:0] q_w [2];

    for (genvar g = 0; g < 2; g++) begin : g_i
        ram_lat_model_if #(.AW(AW), .DW(DW)) bus ();
        assign bus.ram_a  = a;
        assign bus.ram_d  = d;
        assign bus.ram_we = we;
        assign bus.ram_rd = rd;
        assign bus.ram_cs = cs;
        assign rdy_w[g]   = bus.ram_rdy;
        assign busy_w[g]  = bus.ram_busy;
        assign q_w[g]     = bus.ram_q;
        ram_lat_model #(
            .AW(AW), .DW(DW), .RD_LAT(g ? LAT1 : LAT0),
            .REF_PERIOD(g ? PER1 : 0), .REF_CYCLES(CYC)
        ) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );
    end

    typedef struct {int g; int due; int adr;} rd_t;
    logic [DW-1:0] mem_m [int];
    rd_t           pend [$];
    int            n_m [2];
    logic          rdy_m [2];
    logic          busy_m [2];
    logic [DW-1:0] q_m [2];
    int            n_cmp = 0;
    int            n_mis = 0;

    function automatic logic [DW-1:0] peek(int g, int adr);
        int k = g * 65536 + adr;
        return mem_m.exists(k) ? mem_m[k] : '0;
    endfunction

    // Refresh windows follow from edge count alone: busy for the last CYC of every PER1+CYC edges.
    function automatic bit busy_at(int g, int k);
        return g == 1 && (k % (PER1 + CYC)) >= PER1;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            n_m[g]    = 0;
            rdy_m[g]  = 1'b0;
            busy_m[g] = 1'b0;
            q_m[g]    = '0;
        end
        pend.delete();
    endtask

    task automatic step(int g);
        bit            acc;
        logic [DW-1:0] w;
        acc = cs && !busy_at(g, n_m[g]) && (rd || we != 0);
        n_m[g]++;
        rdy_m[g] = 1'b0;
        for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].g == g) begin
                if (pend[i].due == n_m[g]) begin
                    rdy_m[g] = 1'b1;
                    q_m[g]   = peek(g, pend[i].adr);
                    pend.delete(i);
                end
                break;
            end
        end
        if (acc && we != 0) begin
            w = peek(g, int'(a));
            for (int b = 0; b < 2; b++) if (we[b]) w[8*b +: 8] = d[8*b +: 8];
            mem_m[g * 65536 + int'(a)] = w;
        end
        if (acc && rd) pend.push_back('{g, n_m[g] + (g ? LAT1 : LAT0), int'(a)});
        busy_m[g] = busy_at(g, n_m[g]);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) for (int g = 0; g < 2; g++) step(g);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("model%0d_rdy", g), 32'(rdy_w[g]), 32'(rdy_m[g]));
            chk($sformatf("model%0d_busy", g), 32'(busy_w[g]), 32'(busy_m[g]));
            chk($sformatf("model%0d_q", g), 32'(q_w[g]), 32'(q_m[g]));
        end
    endtask

    task automatic idle();
        cs = 1'b0;
        rd = 1'b0;
        we = 2'b00;
    endtask

    task automatic wr(int ad, logic [1:0] w, logic [DW-1:0] dd);
        cs = 1'b1;
        rd = 1'b0;
        a  = AW'(ad);
        we = w;
        d  = dd;
        tick();
        idle();
    endtask

    task automatic rd_chk(int ad, logic [1:0] w, logic [DW-1:0] dd, logic [DW-1:0] ex, string nm);
        cs = 1'b1;
        rd = 1'b1;
        a  = AW'(ad);
        we = w;
        d  = dd;
        tick();
        idle();
        tick();
        chk({nm, "_rdy0"}, 32'(rdy_w[0]), 32'd1);
        chk({nm, "_q0"}, 32'(q_w[0]), 32'(ex));
        tick();
        tick();
        chk({nm, "_rdy1"}, 32'(rdy_w[1]), 32'd1);
        chk({nm, "_q1"}, 32'(q_w[1]), 32'(ex));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        a = '0;
        d = '0;
        idle();
        model_reset();
        repeat (3) begin
            tick();
            chk("reset_rdy", 32'(rdy_w), 32'd0);
            chk("reset_busy", 32'(busy_w), 32'd0);
        end
        rst_n = 1'b1;

        wr(5, 2'b11, 16'h1234);
        wr(5, 2'b10, 16'hAB00);
        rd_chk(5, 2'b00, 16'h0, 16'hAB34, "lanes");
        wr('h10, 2'b11, 16'hBEEF);
        rd_chk('h10, 2'b00, 16'h0, 16'hBEEF, "first_read");

        wr(1, 2'b11, 16'h0011);
        wr(2, 2'b11, 16'h0022);
        wr(3, 2'b11, 16'h0033);
        cs = 1'b1;
        rd = 1'b1;
        a  = 1;
        tick();
        a = 2;
        tick();
        a = 3;
        tick();
        idle();
        chk("pipe_early", 32'(rdy_w[1]), 32'd0);
        tick();
        chk("pipe_rdy_a", 32'(rdy_w[1]), 32'd1);
        chk("pipe_q_a", 32'(q_w[1]), 32'h11);
        tick();
        chk("pipe_rdy_b", 32'(rdy_w[1]), 32'd1);
        chk("pipe_q_b", 32'(q_w[1]), 32'h22);
        tick();
        chk("pipe_rdy_c", 32'(rdy_w[1]), 32'd1);
        chk("pipe_q_c", 32'(q_w[1]), 32'h33);
        tick();
        chk("pipe_end", 32'(rdy_w[1]), 32'd0);
        chk("pipe_hold", 32'(q_w[1]), 32'h33);

        rd_chk(7, 2'b11, 16'h5A5A, 16'h5A5A, "rd_we_same");
        rd_chk(9, 2'b00, 16'h0, 16'h0000, "unwritten");

        while (n_m[1] < 99) tick();
        chk("ref_pre", 32'(busy_w[1]), 32'd0);
        tick();
        chk("ref_rise", 32'(busy_w[1]), 32'd1);
        cs = 1'b1;
        rd = 1'b1;
        a  = 5;
        t  = 0;
        while (busy_w[1] && t < 20) begin
            chk("ref_no_rdy", 32'(rdy_w[1]), 32'd0);
            tick();
            t++;
        end
        chk("ref_len", 32'(t), 32'd4);
        tick();
        idle();
        tick();
        chk("ref_wait_a", 32'(rdy_w[1]), 32'd0);
        tick();
        chk("ref_wait_b", 32'(rdy_w[1]), 32'd0);
        tick();
        chk("ref_held_rdy", 32'(rdy_w[1]), 32'd1);
        chk("ref_held_q", 32'(q_w[1]), 32'hAB34);
        while (n_m[1] < 203) tick();
        chk("ref_repeat_pre", 32'(busy_w[1]), 32'd0);
        tick();
        chk("ref_repeat", 32'(busy_w[1]), 32'd1);

        repeat (2000) begin
            cs = $urandom_range(0, 3) != 0;
            rd = 1'($urandom_range(0, 1));
            we = 2'($urandom_range(0, 3));
            a  = AW'($urandom_range(0, 15));
            d  = DW'($urandom);
            tick();
        end
        idle();
        repeat (5) tick();

        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        wr(20, 2'b11, 16'hC0DE);
        cs = 1'b1;
        rd = 1'b1;
        a  = 20;
        tick();
        idle();
        tick();
        tick();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            chk("mid_reset_no_rdy", 32'(rdy_w[1]), 32'd0);
        end
        rd_chk(20, 2'b00, 16'h0, 16'hC0DE, "retained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
